// File: rtl/key_event_filter.sv
// key_event_filter
// Converts a held USB HID keycode level into single-cycle press events with
// frame-paced auto-repeat, and decodes the W/A/S/D/ENTER navigation keys.
// Event output semantics: evt_valid is a one-cycle pulse with no back-pressure.
// evt_code, evt_repeat and the decoded pulses are meaningful only while
// evt_valid=1. They are held at 0 otherwise.
module key_event_filter #(
  parameter logic [7:0] KEY_UP       = 8'h1A,
  parameter logic [7:0] KEY_LEFT     = 8'h04,
  parameter logic [7:0] KEY_DOWN     = 8'h16,
  parameter logic [7:0] KEY_RIGHT    = 8'h07,
  parameter logic [7:0] KEY_ENTER    = 8'h28,
  parameter logic [7:0] REPEAT_DELAY = 8'd20,
  parameter logic [7:0] REPEAT_RATE  = 8'd6,
  parameter logic       REPEAT_EN    = 1'b1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       frame_clk,
  output logic       evt_valid,
  output logic [7:0] evt_code,
  output logic       evt_repeat,
  output logic       evt_up,
  output logic       evt_left,
  output logic       evt_down,
  output logic       evt_right,
  output logic       evt_enter,
  output logic       key_held
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    HELD_DELAY  = 2'd1,
    HELD_REPEAT = 2'd2
  } state_t;

  state_t     state;
  state_t     state_d;
  logic [7:0] kc_q;
  logic [7:0] last_code;
  logic [7:0] last_d;
  logic [7:0] cnt;
  logic [7:0] cnt_d;
  logic [7:0] cnt_inc;
  logic [7:0] thresh;
  logic       s1, s2, s3;
  logic       tick;
  logic       fire;
  logic       fire_repeat;
  logic [7:0] fire_code;

  // Register the keycode and bring frame_clk into the Clk domain.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      kc_q <= 8'h00;
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
    end else begin
      kc_q <= keycode;
      s1   <= frame_clk;
      s2   <= s1;
      s3   <= s2;
    end
  end

  // One Clk-wide pulse per frame_clk rising edge.
  assign tick    = s2 & ~s3;
  assign cnt_inc = cnt + 8'd1;
  // The first repeat waits REPEAT_DELAY ticks. Later repeats wait REPEAT_RATE ticks.
  assign thresh  = (state == HELD_REPEAT) ? REPEAT_RATE : REPEAT_DELAY;

  // Next-state and event decision. Priority is release, then new press, then repeat.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    last_d      = last_code;
    fire        = 1'b0;
    fire_repeat = 1'b0;
    fire_code   = kc_q;
    case (state)
      IDLE: begin
        if (kc_q != 8'h00) begin
          fire    = 1'b1;
          last_d  = kc_q;
          cnt_d   = 8'd0;
          state_d = HELD_DELAY;
        end
      end
      default: begin
        if (kc_q == 8'h00) begin
          state_d = IDLE;
        end else if (kc_q != last_code) begin
          fire    = 1'b1;
          last_d  = kc_q;
          cnt_d   = 8'd0;
          state_d = HELD_DELAY;
        end else if (tick && REPEAT_EN) begin
          // cnt restarts at the threshold, so it never wraps.
          if (cnt_inc == thresh) begin
            fire        = 1'b1;
            fire_repeat = 1'b1;
            fire_code   = last_code;
            cnt_d       = 8'd0;
            state_d     = HELD_REPEAT;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
    endcase
  end

  // State registers and registered event and decode outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      last_code  <= 8'h00;
      cnt        <= 8'd0;
      evt_valid  <= 1'b0;
      evt_code   <= 8'h00;
      evt_repeat <= 1'b0;
      evt_up     <= 1'b0;
      evt_left   <= 1'b0;
      evt_down   <= 1'b0;
      evt_right  <= 1'b0;
      evt_enter  <= 1'b0;
      key_held   <= 1'b0;
    end else begin
      state      <= state_d;
      last_code  <= last_d;
      cnt        <= cnt_d;
      evt_valid  <= fire;
      evt_code   <= fire ? fire_code : 8'h00;
      evt_repeat <= fire_repeat;
      evt_up     <= fire && (fire_code == KEY_UP);
      evt_left   <= fire && (fire_code == KEY_LEFT);
      evt_down   <= fire && (fire_code == KEY_DOWN);
      evt_right  <= fire && (fire_code == KEY_RIGHT);
      evt_enter  <= fire && (fire_code == KEY_ENTER);
      key_held   <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_key_event_filter.sv
// Bench for key_event_filter: three instances that differ only in their
// repeat parameters. Each instance is compared every cycle against a
// behavioural model of the key event rules.
module tb_key_event_filter;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] keycode = 8'h00;
  logic       frame_clk = 1'b0;

  // clock / reset
  always #5 Clk = ~Clk;

  wire       d_valid [3];
  wire [7:0] d_code  [3];
  wire       d_rep   [3];
  wire [4:0] d_dec   [3];  // {up, left, down, right, enter}
  wire       d_held  [3];

  key_event_filter u_dut0 (
    .Clk(Clk), .Reset(Reset), .keycode(keycode), .frame_clk(frame_clk),
    .evt_valid(d_valid[0]), .evt_code(d_code[0]), .evt_repeat(d_rep[0]),
    .evt_up(d_dec[0][4]), .evt_left(d_dec[0][3]), .evt_down(d_dec[0][2]),
    .evt_right(d_dec[0][1]), .evt_enter(d_dec[0][0]), .key_held(d_held[0]));

  key_event_filter #(.REPEAT_DELAY(8'd2)) u_dut1 (
    .Clk(Clk), .Reset(Reset), .keycode(keycode), .frame_clk(frame_clk),
    .evt_valid(d_valid[1]), .evt_code(d_code[1]), .evt_repeat(d_rep[1]),
    .evt_up(d_dec[1][4]), .evt_left(d_dec[1][3]), .evt_down(d_dec[1][2]),
    .evt_right(d_dec[1][1]), .evt_enter(d_dec[1][0]), .key_held(d_held[1]));

  key_event_filter #(.REPEAT_EN(1'b0)) u_dut2 (
    .Clk(Clk), .Reset(Reset), .keycode(keycode), .frame_clk(frame_clk),
    .evt_valid(d_valid[2]), .evt_code(d_code[2]), .evt_repeat(d_rep[2]),
    .evt_up(d_dec[2][4]), .evt_left(d_dec[2][3]), .evt_down(d_dec[2][2]),
    .evt_right(d_dec[2][1]), .evt_enter(d_dec[2][0]), .key_held(d_held[2]));

  int p_delay [3] = '{20, 2, 20};
  int p_rate  [3] = '{6, 6, 6};
  int p_en    [3] = '{1, 1, 0};

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: the code being held (0 = none), ticks since the last event, and
  // how many repeats the current hold has produced.
  logic [7:0] kc_hist = 8'h00;
  logic       h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;
  logic       tick_seen;
  logic [7:0] code_seen;
  int         cyc = 0;
  logic [7:0] m_held  [3] = '{8'h00, 8'h00, 8'h00};
  int         m_ticks [3] = '{0, 0, 0};
  int         m_reps  [3] = '{0, 0, 0};
  int         m_evt   [3] = '{0, 0, 0};
  logic       e_valid [3] = '{1'b0, 1'b0, 1'b0};
  logic       e_rep   [3] = '{1'b0, 1'b0, 1'b0};
  logic       e_held  [3] = '{1'b0, 1'b0, 1'b0};
  logic [7:0] e_code  [3] = '{8'h00, 8'h00, 8'h00};
  logic [4:0] e_dec   [3] = '{5'h0, 5'h0, 5'h0};

  always @(posedge Clk) begin
    cyc++;
    // The keycode and frame rise this edge acts on were sampled at earlier edges.
    tick_seen = h2 & ~h3;
    code_seen = kc_hist;
    for (int i = 0; i < 3; i++) begin
      e_valid[i] = 1'b0;
      e_rep[i]   = 1'b0;
      e_code[i]  = 8'h00;
      if (Reset) begin
        m_held[i]  = 8'h00;
        m_ticks[i] = 0;
        m_reps[i]  = 0;
      end else if (code_seen == 8'h00) begin
        m_held[i] = 8'h00;
      end else if (code_seen != m_held[i]) begin
        m_held[i]  = code_seen;
        m_ticks[i] = 0;
        m_reps[i]  = 0;
        e_valid[i] = 1'b1;
        e_code[i]  = code_seen;
      end else if (tick_seen && p_en[i] != 0) begin
        m_ticks[i]++;
        if (m_ticks[i] == ((m_reps[i] == 0) ? p_delay[i] : p_rate[i])) begin
          e_valid[i] = 1'b1;
          e_rep[i]   = 1'b1;
          e_code[i]  = m_held[i];
          m_ticks[i] = 0;
          m_reps[i]++;
        end
      end
      e_held[i] = (m_held[i] != 8'h00);
      e_dec[i]  = {e_code[i] == 8'h1A, e_code[i] == 8'h04, e_code[i] == 8'h16,
                   e_code[i] == 8'h07, e_code[i] == 8'h28} & {5{e_valid[i]}};
      if (e_valid[i]) m_evt[i]++;
    end
    if (Reset) begin
      kc_hist = 8'h00;
      h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
    end else begin
      h3 = h2; h2 = h1; h1 = frame_clk;
      kc_hist = keycode;
    end
  end

  // Scoreboard: per-cycle compare plus event counters for the literal checks.
  int n_evt [3];
  int n_rep [3];
  int n_dec [3][5];
  int first_evt;

  always @(posedge Clk) begin
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("dut%0d evt_valid", i), d_valid[i], e_valid[i]);
      if (e_valid[i]) begin
        chk($sformatf("dut%0d evt_code", i), d_code[i], e_code[i]);
        chk($sformatf("dut%0d evt_repeat", i), d_rep[i], e_rep[i]);
      end
      chk($sformatf("dut%0d decode", i), d_dec[i], e_dec[i]);
      chk($sformatf("dut%0d key_held", i), d_held[i], e_held[i]);
      if (d_valid[i]) begin
        n_evt[i]++;
        if (d_rep[i]) n_rep[i]++;
      end
      for (int k = 0; k < 5; k++)
        if (d_dec[i][k]) n_dec[i][k]++;
    end
    if (d_valid[0] && first_evt < 0) first_evt = cyc;
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      frame_clk = 1'b1;
      step(2);
      frame_clk = 1'b0;
      step(2);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 3; i++) begin
      n_evt[i] = 0;
      n_rep[i] = 0;
      m_evt[i] = 0;
      for (int k = 0; k < 5; k++) n_dec[i][k] = 0;
    end
    first_evt = -1;
  endtask

  int chg;

  initial begin
    clear_counts();
    step(3);
    chk("reset evt_valid", d_valid[0], 0);
    chk("reset key_held", d_held[0], 0);
    Reset = 1'b0;
    step(3);

    // Tap W: one press, two cycles after the keycode change.
    clear_counts();
    keycode = 8'h1A;
    chg = cyc;
    step(3);
    keycode = 8'h00;
    step(6);
    chk("tap events", n_evt[0], 1);
    chk("tap evt_up", n_dec[0][4], 1);
    chk("tap repeats", n_rep[0], 0);
    chk("tap latency", first_evt - chg, 2);
    chk("tap model events", m_evt[0], 1);
    chk("tap key_held after", d_held[0], 0);

    // Hold D for 40 ticks: repeats after ticks 20, 26, 32, 38.
    clear_counts();
    keycode = 8'h07;
    step(4);
    ticks(40);
    step(4);
    keycode = 8'h00;
    step(6);
    chk("holdD events", n_evt[0], 5);
    chk("holdD repeats", n_rep[0], 4);
    chk("holdD evt_right", n_dec[0][1], 5);
    chk("holdD model events", m_evt[0], 5);
    chk("holdD delay2 events", n_evt[1], 8);
    chk("holdD no-repeat events", n_evt[2], 1);

    // W held, switch directly to A after 10 ticks, then 20 more ticks.
    clear_counts();
    keycode = 8'h1A;
    step(4);
    ticks(10);
    keycode = 8'h04;
    step(4);
    ticks(20);
    step(4);
    keycode = 8'h00;
    step(6);
    chk("switch events", n_evt[0], 3);
    chk("switch repeats", n_rep[0], 1);
    chk("switch evt_left", n_dec[0][3], 2);
    chk("switch evt_up", n_dec[0][4], 1);
    chk("switch model events", m_evt[0], 3);
    chk("switch delay2 events", n_evt[1], 8);

    // Release lands in the same cycle as the threshold tick (delay 2).
    clear_counts();
    keycode = 8'h16;
    step(4);
    ticks(1);
    frame_clk = 1'b1;
    step(1);
    keycode = 8'h00;
    step(1);
    frame_clk = 1'b0;
    step(6);
    chk("release-tick events", n_evt[1], 1);
    chk("release-tick repeats", n_rep[1], 0);
    chk("release-tick model events", m_evt[1], 1);
    chk("release-tick key_held", d_held[1], 0);

    // Reset for one cycle while ENTER stays held.
    keycode = 8'h28;
    step(4);
    ticks(3);
    clear_counts();
    Reset = 1'b1;
    step(1);
    chk("midreset evt_valid", d_valid[0], 0);
    chk("midreset key_held", d_held[0], 0);
    Reset = 1'b0;
    step(6);
    chk("postreset events", n_evt[0], 1);
    chk("postreset evt_enter", n_dec[0][0], 1);
    chk("postreset repeats", n_rep[0], 0);
    chk("postreset model events", m_evt[0], 1);
    keycode = 8'h00;
    step(6);

    // Hold S for 300 ticks.
    clear_counts();
    keycode = 8'h16;
    step(4);
    ticks(300);
    step(4);
    keycode = 8'h00;
    step(6);
    chk("norepeat events", n_evt[2], 1);
    chk("norepeat model events", m_evt[2], 1);
    chk("long hold default events", n_evt[0], 48);
    chk("long hold delay2 events", n_evt[1], 51);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
